// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_pkg : shared seven-segment code table and decode helper          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high gfedcba codes, entry 15 first so SEG7_TABLE[n] is digit n.
  localparam logic [15:0][6:0] SEG7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
    return SEG7_TABLE[nibble];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_blink_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_blink_timer : free-running blink phase generator with restart    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module seg7_blink_timer #(
  parameter int BLINK_DIV = 101
) (
  input  logic fs,
  input  logic rst_n,
  input  logic blink_sync,
  output logic blink_off
);

  localparam int            CW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          blink_off_q, blink_off_d;

  // A restart wins over a terminal-count toggle landing on the same edge.
  always_comb begin
    cnt_d       = cnt_q + CW'(1);
    blink_off_d = blink_off_q;
    if (blink_sync) begin
      cnt_d       = '0;
      blink_off_d = 1'b0;
    end else if (cnt_q == C_CNT_LAST) begin
      cnt_d       = '0;
      blink_off_d = ~blink_off_q;
    end
  end

  always_ff @(posedge fs or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      blink_off_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  assign blink_off = blink_off_q;

endmodule
`default_nettype wire

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan_mux : multiplexed seven-segment scan driver with blink/dp   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 1,
  parameter int BLINK_DIV      = 101,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    fs,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blink_sync,
  output logic [NUM_DIGITS-1:0]   led_dig,
  output logic [7:0]              display,
  output logic [IW-1:0]           scan_idx
);

  localparam int                    PW           = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]         C_PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         C_IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] C_DIG_IDLE   = {NUM_DIGITS{DIG_ACTIVE_LOW}};
  localparam logic [7:0]            C_SEG_IDLE   = {8{SEG_ACTIVE_LOW}};

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         scan_idx_q, scan_idx_d;
  logic [NUM_DIGITS-1:0] led_dig_q, led_dig_d;
  logic [7:0]            display_q, display_d;

  logic                  w_blink_off;
  logic [NUM_DIGITS-1:0] w_sel;
  logic [3:0]            w_nib;
  logic                  w_en, w_bm, w_dp, w_blank, w_dp_lit;
  logic [6:0]            w_seg;

  seg7_blink_timer #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .fs         (fs),
    .rst_n      (rst_n),
    .blink_sync (blink_sync),
    .blink_off  (w_blink_off)
  );

  // Scan index wraps at NUM_DIGITS so unused binary codes are never visited.
  always_comb begin
    presc_d    = presc_q + PW'(1);
    scan_idx_d = scan_idx_q;
    if (presc_q == C_PRESC_LAST) begin
      presc_d    = '0;
      scan_idx_d = (scan_idx_q == C_IDX_LAST) ? '0 : scan_idx_q + IW'(1);
    end
  end

  always_comb begin
    w_sel = '0;
    w_nib = '0;
    w_en  = 1'b0;
    w_bm  = 1'b0;
    w_dp  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx_q == IW'(i)) begin
        w_sel[i] = 1'b1;
        w_nib    = digits[4*i +: 4];
        w_en     = dig_en[i];
        w_bm     = blink_mask[i];
        w_dp     = dp_mask[i];
      end
    end
    w_blank  = ~w_en | (w_bm & w_blink_off);
    w_seg    = w_blank ? SEG_BLANK : seg7_decode(w_nib);
    w_dp_lit = ~w_blank & w_dp;
    // A blanked digit keeps its select asserted so every slot has equal duty.
    led_dig_d = DIG_ACTIVE_LOW ? ~w_sel : w_sel;
    display_d = SEG_ACTIVE_LOW ? ~{w_dp_lit, w_seg} : {w_dp_lit, w_seg};
  end

  always_ff @(posedge fs or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      scan_idx_q <= '0;
      led_dig_q  <= C_DIG_IDLE;
      display_q  <= C_SEG_IDLE;
    end else begin
      presc_q    <= presc_d;
      scan_idx_q <= scan_idx_d;
      led_dig_q  <= led_dig_d;
      display_q  <= display_d;
    end
  end

  assign led_dig  = led_dig_q;
  assign display  = display_q;
  assign scan_idx = scan_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg7_scan_mux : randomized bench against a behavioural scan model  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_seg7_scan_mux;

  logic        fs = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] digits = '0;
  logic [7:0]  dig_en = '0;
  logic [7:0]  blink_mask = '0;
  logic [7:0]  dp_mask = '0;
  logic        blink_sync = 1'b0;

  logic [7:0]  led_a, disp_a;
  logic [2:0]  idx_a;
  logic [5:0]  led_b;
  logic [7:0]  disp_b;
  logic [2:0]  idx_b;

  int tests_run = 0;
  int tests_failed = 0;
  int k = 0;  // edges since reset
  int m = 0;  // edges since reset or last blink restart

  logic [6:0] seg_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 fs = ~fs;

  // A: 8 digits, scan every cycle, blink half-period 4, active-low outputs
  seg7_scan_mux #(
    .NUM_DIGITS(8), .SCAN_DIV(1), .BLINK_DIV(4),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut_a (
    .fs(fs), .rst_n(rst_n), .digits(digits), .dig_en(dig_en),
    .blink_mask(blink_mask), .dp_mask(dp_mask), .blink_sync(blink_sync),
    .led_dig(led_a), .display(disp_a), .scan_idx(idx_a)
  );

  // B: 6 digits, 3 cycles per digit, blink half-period 5, active-high outputs
  seg7_scan_mux #(
    .NUM_DIGITS(6), .SCAN_DIV(3), .BLINK_DIV(5),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) dut_b (
    .fs(fs), .rst_n(rst_n), .digits(digits[23:0]), .dig_en(dig_en[5:0]),
    .blink_mask(blink_mask[5:0]), .dp_mask(dp_mask[5:0]), .blink_sync(blink_sync),
    .led_dig(led_b), .display(disp_b), .scan_idx(idx_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // Expected {led[15:0], display[7:0]} for the edge after e edges since reset
  // and b edges since the last blink restart.
  function automatic logic [23:0] model(input int nd, input int sd, input int bd,
                                        input bit sal, input bit dal,
                                        input int e, input int b);
    int         i;
    bit         boff, blank;
    logic [15:0] sel, led;
    logic [7:0]  disp;
    i     = (e / sd) % nd;
    boff  = ((b / bd) % 2) == 1;
    blank = !dig_en[i] || (blink_mask[i] && boff);
    sel   = 16'(1) << i;
    led   = dal ? (~sel & 16'((1 << nd) - 1)) : sel;
    disp  = blank ? 8'h00 : {dp_mask[i], seg_ref[digits[4*i +: 4]]};
    if (sal) disp = ~disp;
    return {led, disp};
  endfunction

  task automatic run_cycle(input logic [31:0] d, input logic [7:0] e, input logic [7:0] bm,
                           input logic [7:0] dp, input logic s);
    logic [23:0] ea, eb;
    @(negedge fs);
    digits = d; dig_en = e; blink_mask = bm; dp_mask = dp; blink_sync = s;
    ea = model(8, 1, 4, 1'b1, 1'b1, k, m);
    eb = model(6, 3, 5, 1'b0, 1'b0, k, m);
    @(posedge fs);
    #1;
    k++;
    m = s ? 0 : m + 1;
    chk("A_led", 32'(led_a), 32'(ea[15:8]));
    chk("A_disp", 32'(disp_a), 32'(ea[7:0]));
    chk("A_idx", 32'(idx_a), 32'(k % 8));
    chk("B_led", 32'(led_b), 32'(eb[13:8]));
    chk("B_disp", 32'(disp_b), 32'(eb[7:0]));
    chk("B_idx", 32'(idx_b), 32'((k / 3) % 6));
  endtask

  task automatic run_random(input int n, input int sync_odds);
    for (int c = 0; c < n; c++)
      run_cycle($urandom, 8'($urandom), 8'($urandom), 8'($urandom),
                ($urandom_range(sync_odds - 1, 0) == 0));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_A_led"}, 32'(led_a), 32'h0000_00FF);
    chk({tag, "_A_disp"}, 32'(disp_a), 32'h0000_00FF);
    chk({tag, "_A_idx"}, 32'(idx_a), 32'h0);
    chk({tag, "_B_led"}, 32'(led_b), 32'h0);
    chk({tag, "_B_disp"}, 32'(disp_b), 32'h0);
    chk({tag, "_B_idx"}, 32'(idx_b), 32'h0);
  endtask

  initial begin
    int guard;
    #2 rst_n = 1'b0;
    #1 check_idle("rst");
    @(posedge fs);
    @(posedge fs);
    #2 rst_n = 1'b1;
    k = 0;
    m = 0;

    // Scan order and decimal decode
    for (int c = 0; c < 16; c++) run_cycle(32'h7654_3210, 8'hFF, 8'h00, 8'h00, 1'b0);
    // Hex decode on slot 0
    for (int c = 0; c < 48; c++)
      run_cycle({28'h765_4321, 4'(10 + (c / 8) % 6)}, 8'hFF, 8'h00, 8'h00, 1'b0);
    // Enable and decimal point masks
    for (int c = 0; c < 24; c++) run_cycle(32'h7654_3210, 8'h0F, 8'h00, 8'h04, 1'b0);
    // Blink with restart pulses while blanked
    for (int c = 0; c < 60; c++)
      run_cycle(32'h7654_3210, 8'hFF, 8'h0C, 8'h00, (c == 22) || (c == 45));
    run_random(300, 24);

    // Asynchronous reset in the middle of a scan at index 5
    guard = 0;
    while ((k % 8) != 5 && guard < 20) begin
      run_random(1, 24);
      guard++;
    end
    chk("pre_rst_idx", 32'(idx_a), 32'h5);
    #2 rst_n = 1'b0;
    #1 check_idle("midrst");
    @(posedge fs);
    #2 rst_n = 1'b1;
    k = 0;
    m = 0;
    run_random(200, 16);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
